elevator_datapath: RTL and testbench

Datapath partner of the elevator control FSM. It consumes the FSM's enable strobes (`input_en`, `update_dir*`, `update_now_en`, `update_des_en`, `rst_des_en`, `is_move`) and returns the two status signals the FSM decides on: `comparator_result` and `input_bool`. It holds the hall/cabin request register, the direction, the current and destination floor registers, and the per-floor travel timer.

---
 rtl/elevator_datapath.sv | 140 ++++++++++++++
 tb/tb_elevator_datapath.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/elevator_datapath.sv
// Elevator datapath: request register, direction, current/destination floor
// registers and per-floor travel timer. Returns the comparator and
// any-request status used by the control FSM.
module elevator_datapath #(
    parameter int FLOORS     = 8,
    parameter int FW         = 3,
    parameter int MOVE_TICKS = 4
) (
    input  logic              clk,
    input  logic              irst,
    input  logic [FLOORS-1:0] ibutton,
    input  logic              iinput_en,
    input  logic              iupdate_dir,
    input  logic              iupdate_dir_en,
    input  logic              iupdate_des_en,
    input  logic              iupdate_now_en,
    input  logic              irst_des_en,
    input  logic              is_move,
    output logic [2:0]        comparator_result,
    output logic              input_bool,
    output logic [FW-1:0]     onow_floor,
    output logic [FW-1:0]     odes_floor,
    output logic              odir,
    output logic [FLOORS-1:0] orequests,
    output logic              ostep
);

    // A one-tick journey still needs a 1-bit timer that simply stays at 0.
    localparam int TW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam logic [TW-1:0]     TMAX     = TW'(MOVE_TICKS - 1);
    localparam logic [FW-1:0]     FTOP     = FW'(FLOORS - 1);
    localparam logic [FLOORS-1:0] REQ_ONE  = FLOORS'(1);
    localparam logic [FLOORS-1:0] REQ_ZERO = {FLOORS{1'b0}};

    logic [FLOORS-1:0] req_q, req_d;
    logic              dir_q, dir_d;
    logic [FW-1:0]     now_q, now_d;
    logic [FW-1:0]     des_q, des_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              step_q, step_d;

    logic [FW-1:0]     above_s, below_s, sel_s;
    logic              above_found_s, below_found_s;
    logic              up_ok_s, dn_ok_s, wrap_s;
    logic              hit_s;

    // Nearest requested floor strictly above and strictly below the car.
    always_comb begin
        above_s       = {FW{1'b0}};
        below_s       = {FW{1'b0}};
        above_found_s = 1'b0;
        below_found_s = 1'b0;
        hit_s         = 1'b0;
        // Descending scan: the last hit is the lowest floor above.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            hit_s         = req_q[i] && (FW'(i) > now_q);
            above_s       = hit_s ? FW'(i) : above_s;
            above_found_s = above_found_s | hit_s;
        end
        // Ascending scan: the last hit is the highest floor below.
        for (int i = 0; i < FLOORS; i++) begin
            hit_s         = req_q[i] && (FW'(i) < now_q);
            below_s       = hit_s ? FW'(i) : below_s;
            below_found_s = below_found_s | hit_s;
        end
    end

    // Direction-priority target selection, falling back to the current floor.
    always_comb begin
        sel_s = now_q;
        if (dir_q) begin
            if (above_found_s)      sel_s = above_s;
            else if (below_found_s) sel_s = below_s;
            else                    sel_s = now_q;
        end else begin
            if (below_found_s)      sel_s = below_s;
            else if (above_found_s) sel_s = above_s;
            else                    sel_s = now_q;
        end
    end

    // Next-state for requests, direction, destination, timer and floor.
    always_comb begin
        // Clear of the served floor overrides a same-cycle set on that bit.
        req_d   = (req_q | (iinput_en ? ibutton : REQ_ZERO))
                  & ~(irst_des_en ? (REQ_ONE << now_q) : REQ_ZERO);
        dir_d   = iupdate_dir_en ? iupdate_dir : dir_q;
        des_d   = iupdate_des_en ? sel_s : des_q;

        up_ok_s = (des_q > now_q) && (now_q != FTOP);
        dn_ok_s = (des_q < now_q) && (now_q != {FW{1'b0}});
        wrap_s  = is_move && iupdate_now_en && (timer_q == TMAX);

        if (!is_move) begin
            timer_d = {TW{1'b0}};
        end else if (iupdate_now_en) begin
            timer_d = wrap_s ? {TW{1'b0}} : (timer_q + TW'(1));
        end else begin
            timer_d = timer_q;
        end

        // Step uses the pre-update destination.
        step_d = wrap_s && (up_ok_s || dn_ok_s);
        if (wrap_s && up_ok_s) begin
            now_d = now_q + FW'(1);
        end else if (wrap_s && dn_ok_s) begin
            now_d = now_q - FW'(1);
        end else begin
            now_d = now_q;
        end
    end

    // State registers with synchronous reset; reset aborts any travel.
    always_ff @(posedge clk) begin
        if (irst) begin
            req_q   <= REQ_ZERO;
            dir_q   <= 1'b1;
            now_q   <= {FW{1'b0}};
            des_q   <= {FW{1'b0}};
            timer_q <= {TW{1'b0}};
            step_q  <= 1'b0;
        end else begin
            req_q   <= req_d;
            dir_q   <= dir_d;
            now_q   <= now_d;
            des_q   <= des_d;
            timer_q <= timer_d;
            step_q  <= step_d;
        end
    end

    assign comparator_result = {(des_q > now_q), (des_q == now_q), (des_q < now_q)};
    assign input_bool        = |req_q;
    assign onow_floor        = now_q;
    assign odes_floor        = des_q;
    assign odir              = dir_q;
    assign orequests         = req_q;
    assign ostep             = step_q;

endmodule

// File: tb/tb_elevator_datapath.sv
// Directed, table-driven bench for elevator_datapath (FLOORS=8, MOVE_TICKS=4).
module tb_elevator_datapath;

    typedef struct {
        string      nm;
        logic       rst;
        logic [7:0] btn;
        logic       in_en, dir, dir_en, des_en, now_en, rst_des, mv;
        logic [2:0] e_now, e_des;
        logic       e_dir;
        logic [7:0] e_req;
        logic [2:0] e_cmp;
        logic       e_ib, e_step;
    } vec_t;

    logic       clk = 1'b0;
    logic       irst, iinput_en, iupdate_dir, iupdate_dir_en, iupdate_des_en;
    logic       iupdate_now_en, irst_des_en, is_move;
    logic [7:0] ibutton;
    logic [2:0] comparator_result, onow_floor, odes_floor;
    logic       input_bool, odir, ostep;
    logic [7:0] orequests;

    int n_checks = 0;
    int n_fail   = 0;
    int vidx     = 0;
    int pulses   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    elevator_datapath #(.FLOORS(8), .FW(3), .MOVE_TICKS(4)) dut (
        .clk(clk), .irst(irst), .ibutton(ibutton), .iinput_en(iinput_en),
        .iupdate_dir(iupdate_dir), .iupdate_dir_en(iupdate_dir_en),
        .iupdate_des_en(iupdate_des_en), .iupdate_now_en(iupdate_now_en),
        .irst_des_en(irst_des_en), .is_move(is_move),
        .comparator_result(comparator_result), .input_bool(input_bool),
        .onow_floor(onow_floor), .odes_floor(odes_floor), .odir(odir),
        .orequests(orequests), .ostep(ostep)
    );

    function automatic vec_t mk(string nm, logic rst, logic [7:0] btn, logic in_en,
                                logic dir, logic dir_en, logic des_en, logic now_en,
                                logic rst_des, logic mv, logic [2:0] e_now,
                                logic [2:0] e_des, logic e_dir, logic [7:0] e_req,
                                logic [2:0] e_cmp, logic e_ib, logic e_step);
        vec_t v;
        v.nm = nm; v.rst = rst; v.btn = btn; v.in_en = in_en; v.dir = dir;
        v.dir_en = dir_en; v.des_en = des_en; v.now_en = now_en;
        v.rst_des = rst_des; v.mv = mv; v.e_now = e_now; v.e_des = e_des;
        v.e_dir = e_dir; v.e_req = e_req; v.e_cmp = e_cmp; v.e_ib = e_ib;
        v.e_step = e_step;
        return v;
    endfunction

    function automatic logic [2:0] cmpf(int d, int n);
        return {(d > n), (d == n), (d < n)};
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, got, exp);
        end
    endtask

    // Drive one vector, clock it in, then compare every output.
    task automatic run(vec_t v);
        irst = v.rst; ibutton = v.btn; iinput_en = v.in_en; iupdate_dir = v.dir;
        iupdate_dir_en = v.dir_en; iupdate_des_en = v.des_en;
        iupdate_now_en = v.now_en; irst_des_en = v.rst_des; is_move = v.mv;
        @(posedge clk);
        #1;
        vidx++;
        if (ostep === 1'b1) pulses++;
        chk({v.nm, ".now"},  vidx, 32'(onow_floor),        32'(v.e_now));
        chk({v.nm, ".des"},  vidx, 32'(odes_floor),        32'(v.e_des));
        chk({v.nm, ".dir"},  vidx, 32'(odir),              32'(v.e_dir));
        chk({v.nm, ".req"},  vidx, 32'(orequests),         32'(v.e_req));
        chk({v.nm, ".cmp"},  vidx, 32'(comparator_result), 32'(v.e_cmp));
        chk({v.nm, ".ib"},   vidx, 32'(input_bool),        32'(v.e_ib));
        chk({v.nm, ".step"}, vidx, 32'(ostep),             32'(v.e_step));
    endtask

    // Travel with is_move and iupdate_now_en held, timer starting at 0.
    task automatic travel(string nm, int edges, int start, int sgn, int des,
                          logic [7:0] req, logic d);
        int n;
        for (int k = 1; k <= edges; k++) begin
            n = start + sgn * (k / 4);
            run(mk(nm, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                   3'(n), 3'(des), d, req, cmpf(des, n), |req, (k % 4) == 0));
        end
    endtask

    initial begin
        // Reset, requests and first destination load.
        tbl.push_back(mk("reset",    1,8'h00,0,0,0,0,0,0,0, 3'd0,3'd0,1,8'h00,3'b010,0,0));
        tbl.push_back(mk("des_none", 0,8'h00,0,0,0,1,0,0,0, 3'd0,3'd0,1,8'h00,3'b010,0,0));
        tbl.push_back(mk("btn5",     0,8'h20,1,0,0,0,0,0,0, 3'd0,3'd0,1,8'h20,3'b010,1,0));
        tbl.push_back(mk("btn_noen", 0,8'h08,0,0,0,0,0,0,0, 3'd0,3'd0,1,8'h20,3'b010,1,0));
        tbl.push_back(mk("load5",    0,8'h00,0,0,0,1,0,0,0, 3'd0,3'd5,1,8'h20,3'b100,1,0));

        foreach (tbl[i]) run(tbl[i]);
        tbl.delete();

        pulses = 0;
        travel("up0to5", 20, 0, 1, 5, 8'h20, 1'b1);
        chk("pulses0to5", vidx, 32'(pulses), 32'd5);

        // Arrival clear beats a same-cycle set; other bits still set.
        tbl.push_back(mk("arr_clr",  0,8'h20,1,0,0,0,0,1,0, 3'd5,3'd5,1,8'h00,3'b010,0,0));
        tbl.push_back(mk("arr_oth",  0,8'h21,1,0,0,0,0,1,0, 3'd5,3'd5,1,8'h01,3'b010,1,0));
        tbl.push_back(mk("reset2",   1,8'h00,0,0,0,0,0,0,0, 3'd0,3'd0,1,8'h00,3'b010,0,0));
        tbl.push_back(mk("btn4",     0,8'h10,1,0,0,0,0,0,0, 3'd0,3'd0,1,8'h10,3'b010,1,0));
        tbl.push_back(mk("load4",    0,8'h00,0,0,0,1,0,0,0, 3'd0,3'd4,1,8'h10,3'b100,1,0));
        foreach (tbl[i]) run(tbl[i]);
        tbl.delete();

        travel("up0to4", 16, 0, 1, 4, 8'h10, 1'b1);

        // Direction priority at floor 4.
        tbl.push_back(mk("only1",    0,8'h02,1,0,0,0,0,1,0, 3'd4,3'd4,1,8'h02,3'b010,1,0));
        tbl.push_back(mk("up_fb1",   0,8'h00,0,0,0,1,0,0,0, 3'd4,3'd1,1,8'h02,3'b001,1,0));
        tbl.push_back(mk("btn6",     0,8'h40,1,0,0,0,0,0,0, 3'd4,3'd1,1,8'h42,3'b001,1,0));
        tbl.push_back(mk("up6",      0,8'h00,0,0,0,1,0,0,0, 3'd4,3'd6,1,8'h42,3'b100,1,0));
        tbl.push_back(mk("olddir",   0,8'h00,0,0,1,1,0,0,0, 3'd4,3'd6,0,8'h42,3'b100,1,0));
        tbl.push_back(mk("down1",    0,8'h00,0,0,0,1,0,0,0, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        foreach (tbl[i]) run(tbl[i]);
        tbl.delete();

        // Timer hold: 2 ticks, a held cycle, drop is_move, then a full 4 ticks.
        run(mk("hold_t1",  0,8'h00,0,0,0,0,1,0,1, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("hold_t2",  0,8'h00,0,0,0,0,1,0,1, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("hold_en0", 0,8'h00,0,0,0,0,0,0,1, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("hold_mv0", 0,8'h00,0,0,0,0,0,0,0, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("resume1",  0,8'h00,0,0,0,0,1,0,1, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("resume2",  0,8'h00,0,0,0,0,1,0,1, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("resume3",  0,8'h00,0,0,0,0,1,0,1, 3'd4,3'd1,0,8'h42,3'b001,1,0));
        run(mk("resume4",  0,8'h00,0,0,0,0,1,0,1, 3'd3,3'd1,0,8'h42,3'b001,1,1));
        travel("dn3to2", 4, 3, -1, 1, 8'h42, 1'b0);

        // Retarget upward to floor 3, then reset with the timer at 3.
        run(mk("btn37",    0,8'h88,1,0,0,0,0,0,0, 3'd2,3'd1,0,8'hca,3'b001,1,0));
        run(mk("olddir2",  0,8'h00,0,1,1,1,0,0,0, 3'd2,3'd1,1,8'hca,3'b001,1,0));
        run(mk("up3",      0,8'h00,0,0,0,1,0,0,0, 3'd2,3'd3,1,8'hca,3'b100,1,0));
        travel("to_t3", 3, 2, 1, 3, 8'hca, 1'b1);
        run(mk("rst_move", 1,8'h00,0,0,0,0,1,0,1, 3'd0,3'd0,1,8'h00,3'b010,0,0));
        run(mk("post_rst", 0,8'h00,0,0,0,0,0,0,0, 3'd0,3'd0,1,8'h00,3'b010,0,0));

        // dir=0 with nothing below falls back to the lowest floor above.
        run(mk("btn26dn",  0,8'h44,1,0,1,0,0,0,0, 3'd0,3'd0,0,8'h44,3'b010,1,0));
        run(mk("dn_fb2",   0,8'h00,0,0,0,1,0,0,0, 3'd0,3'd2,0,8'h44,3'b100,1,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
